benes_stream: RTL
=================

// Module: benes_stream
// PURPOSE
//  Pipelined SIZE-lane Benes permutation network with valid/ready flow control and per-lane valid mask.
//  Switch settings come from a stored config register or travel per-beat with the data, so the route can change every beat.
//  Sits between the operand buffers and the tensor-core lanes as the streaming successor of the fixed-control Benes xbar.
// PARAMETERS
//  SIZE          32        lanes; power of 2, >=4
//  DWIDTH        16        bits per lane
//  REGISTER_MASK 8'hFF     bit s=1 -> pipeline register after switch stage s (s < STAGES-1; other bits ignored)
//  CTRL_MODE     0         0: route from cfg register; 1: route from in_ctrl sampled with each beat
//  (local) TAGWIDTH=$clog2(SIZE), STAGES=2*TAGWIDTH-1, BITWIDTH=STAGES*SIZE/2, L=popcount(REGISTER_MASK[STAGES-2:0])
// PORTS
//  clk           in   1                 clock
//  n_rst         in   1                 asynchronous active-low reset
//  cfg_we        in   1                 load cfg_bits into cfg register this cycle (CTRL_MODE=0)
//  cfg_bits      in   BITWIDTH          switch controls; bit (SIZE/2)*s+k drives switch k of stage s
//  in_valid      in   1                 input beat valid
//  in_ready      out  1                 network accepts beat when in_valid&&in_ready
//  in_data       in   SIZE*DWIDTH       lane i = [i*DWIDTH +: DWIDTH]
//  in_lane_vld   in   SIZE              per-lane valid, routed alongside the data
//  in_ctrl       in   BITWIDTH          per-beat switch controls (CTRL_MODE=1)
//  out_valid     out  1                 output beat valid
//  out_ready     in   1                 downstream accepts when out_valid&&out_ready
//  out_data      out  SIZE*DWIDTH       permuted lanes
//  out_lane_vld  out  SIZE              permuted lane valids
//  cfg_q         out  BITWIDTH          current cfg register contents
// BEHAVIOUR
//  - Switch: cntrl=0 passes (a,b)->(a,b); cntrl=1 swaps. Each lane carries DWIDTH+1 bits (data + lane valid).
//  - Stage s pairs lanes (g*2d+j, g*2d+j+d), d=2^min(s,STAGES-1-s), j<d; control bit (SIZE/2)*s + g*d + j.
//  - Each beat's full BITWIDTH control word is captured at acceptance and carried with the beat through every
//    register boundary; later cfg_we or in_ctrl changes never alter an in-flight beat.
//  - CTRL_MODE=0: a beat accepted in the same cycle as cfg_we uses the OLD cfg; new value applies from the next beat.
//  - Per register boundary b: valid_b, data_b, ctrl_b. Boundary loads when !valid_b || ready_{b+1}.
//    in_ready = !valid_0 || ready_1; the last boundary's ready = out_ready. Full throughput: 1 beat/cycle, no bubbles.
//  - Latency: a beat accepted at edge t presents on out_* after edge t+L when never stalled.
//    L=0: fully combinational; out_valid=in_valid, in_ready=out_ready.
//  - Stall: while out_valid && !out_ready, out_data/out_lane_vld/out_valid hold stable; no beat is dropped or duplicated.
//  - Bubbles collapse: an empty boundary loads even if downstream is stalled.
//  - out_data/out_lane_vld are data-only: undefined-free (driven from last stage), but qualified by out_valid.
//  - Reset (async, any time incl. mid-stream): all valid_b=0, data_b=0, ctrl_b=0, cfg register=0 (identity).
//    Out of reset: out_valid=0, out_data=0, out_lane_vld=0, in_ready=1 (or =out_ready when L=0), cfg_q=0.
//    In-flight beats are discarded; none emerge after reset release.
//  - cfg_we ignored (no effect) when CTRL_MODE=1; in_ctrl ignored when CTRL_MODE=0.
// TESTING  (SIZE=4, DWIDTH=16, STAGES=3, BITWIDTH=6, REGISTER_MASK=8'hFF -> L=2 unless noted)
//  1 reset, in_data={16'h3,16'h2,16'h1,16'h0}, valid 1 beat, cfg=0 -> after 2 edges out_data identical, out_valid 1 cycle
//  2 cfg_we cfg_bits=6'b000001 -> out lanes {3,2,0,1}; cfg_bits=6'b000100 -> out lanes {3,0,1,2} (lane0<->lane2)
//  3 stream 8 beats, out_ready low cycles 3-5 -> in_ready drops once pipe full, out held stable, all 8 beats in order
//  4 cfg_we toggling 6'b000001/6'b000000 on each accept edge -> beat k uses cfg loaded before it; alternating swap
//  5 CTRL_MODE=1, in_ctrl per beat 6'b100000,6'b000010, in_lane_vld=4'b0001 -> lane-valid bit follows data lane
//  6 n_rst asserted with 2 beats in flight -> out_valid 0 immediately, cfg_q=0, no stale beat after release

Source files
------------

// File: rtl/benes_stream.sv
// benes_stream: pipelined SIZE-lane Benes permutation network with valid/ready
// flow control. Each lane carries DWIDTH data bits plus a lane-valid bit. Each
// beat carries its own full control word (from the cfg register or from
// in_ctrl), so the route can change every beat.
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   cfg_we, cfg_bits, cfg_q     config register load / contents (CTRL_MODE=0)
//   in_valid, in_ready          input handshake
//   in_data, in_lane_vld        input lanes (lane i = [i*DWIDTH +: DWIDTH])
//   in_ctrl                     per-beat switch controls (CTRL_MODE=1)
//   out_valid, out_ready        output handshake
//   out_data, out_lane_vld      permuted lanes
//
// Stage s uses control bits [(SIZE/2)*s +: SIZE/2]. A pipeline register is
// placed after stage s when REGISTER_MASK[s]=1 (s < STAGES-1).

module benes_switch #(
    parameter int W = 17
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign x = sel ? b : a;
    assign y = sel ? a : b;
endmodule

module benes_stream #(
    parameter int          SIZE          = 32,
    parameter int          DWIDTH        = 16,
    parameter logic [7:0]  REGISTER_MASK = 8'hFF,
    parameter int          CTRL_MODE     = 0,
    localparam int         TAGWIDTH      = $clog2(SIZE),
    localparam int         STAGES        = 2 * TAGWIDTH - 1,
    localparam int         BITWIDTH      = STAGES * SIZE / 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     cfg_we,
    input  logic [BITWIDTH-1:0]      cfg_bits,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE*DWIDTH-1:0]   in_data,
    input  logic [SIZE-1:0]          in_lane_vld,
    input  logic [BITWIDTH-1:0]      in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE*DWIDTH-1:0]   out_data,
    output logic [SIZE-1:0]          out_lane_vld,
    output logic [BITWIDTH-1:0]      cfg_q
);
    localparam int          W     = DWIDTH + 1;
    localparam int          HALF  = SIZE / 2;
    localparam logic [63:0] RMASK = {56'd0, REGISTER_MASK};

    logic [BITWIDTH-1:0]       cfg_r;
    logic [BITWIDTH-1:0]       ctrl0;
    logic [SIZE-1:0][W-1:0]    lanes_in;
    logic [SIZE-1:0][W-1:0]    lanes_out;
    // empty[s]=1 only for a registered boundary currently holding no beat.
    logic [STAGES-1:0]         empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cfg_r <= '0;
        else if (CTRL_MODE == 0 && cfg_we)
            cfg_r <= cfg_bits;
    end
    assign cfg_q = cfg_r;

    // The old cfg value is what a beat accepted alongside cfg_we picks up.
    assign ctrl0 = (CTRL_MODE != 0) ? in_ctrl : cfg_r;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign lanes_in[i]                     = {in_lane_vld[i], in_data[i*DWIDTH +: DWIDTH]};
        assign out_data[i*DWIDTH +: DWIDTH]    = lanes_out[i][DWIDTH-1:0];
        assign out_lane_vld[i]                 = lanes_out[i][DWIDTH];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int DIST = 1 << ((s < STAGES - 1 - s) ? s : STAGES - 1 - s);
        localparam bit REG  = (s < STAGES - 1) && RMASK[s];

        logic                    v_i, v_o;
        logic [SIZE-1:0][W-1:0]  d_i, d_o, sw;
        logic [BITWIDTH-1:0]     c_i, c_o;

        if (s == 0) begin : g_first
            assign v_i = in_valid;
            assign d_i = lanes_in;
            assign c_i = ctrl0;
        end else begin : g_next
            assign v_i = g_stage[s-1].v_o;
            assign d_i = g_stage[s-1].d_o;
            assign c_i = g_stage[s-1].c_o;
        end

        // Switch k of this stage: lanes (g*2d+j, g*2d+j+d) with k = g*d+j.
        for (genvar k = 0; k < HALF; k++) begin : g_sw
            localparam int LO = (k / DIST) * 2 * DIST + (k % DIST);
            benes_switch #(.W(W)) u_sw (
                .sel (c_i[HALF*s + k]),
                .a   (d_i[LO]),
                .b   (d_i[LO+DIST]),
                .x   (sw[LO]),
                .y   (sw[LO+DIST])
            );
        end

        if (REG) begin : g_reg
            logic                    v_q;
            logic [SIZE-1:0][W-1:0]  d_q;
            logic [BITWIDTH-1:0]     c_q;
            logic                    load;

            // Ready into this boundary: downstream drains, or some later
            // boundary has a hole the beats can shift into.
            assign load = out_ready | (|empty[STAGES-1:s]);

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                    c_q <= '0;
                end else if (load) begin
                    v_q <= v_i;
                    d_q <= sw;
                    c_q <= c_i;
                end
            end

            assign empty[s] = ~v_q;
            assign v_o      = v_q;
            assign d_o      = d_q;
            assign c_o      = c_q;
        end else begin : g_comb
            assign empty[s] = 1'b0;
            assign v_o      = v_i;
            assign d_o      = sw;
            assign c_o      = c_i;
        end
    end

    assign in_ready  = out_ready | (|empty);
    assign out_valid = g_stage[STAGES-1].v_o;
    assign lanes_out = g_stage[STAGES-1].d_o;

    logic unused_ok;
    assign unused_ok = ^{g_stage[STAGES-1].c_o, in_ctrl, cfg_bits};

endmodule
